// File: rtl/multicast_router.sv
// Multicast router: NUM_CH independent channels, each a FIFO feeding a tag-matched
// multicast/broadcast stage that retires an entry only after every targeted column accepts.
module mcr_channel #(
  parameter int NUM_COL    = 4,
  parameter int BUS_W      = 32,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8,
  parameter int COL_W      = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ID_WIDTH-1:0]          in_tag,
  input  logic [BUS_W-1:0]             in_data,
  input  logic                         bcast,
  input  logic                         id_we,
  input  logic [COL_W-1:0]             cfg_col,
  input  logic [ID_WIDTH-1:0]          cfg_id,
  output logic [NUM_COL-1:0]           col_valid,
  output logic [BUS_W-1:0]             col_data,
  input  logic [NUM_COL-1:0]           col_ready,
  output logic                         busy,
  output logic [CNT_W-1:0]             drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [0:0] STATE_IDLE    = 1'b0;
  localparam logic [0:0] STATE_DELIVER = 1'b1;

  logic [ID_WIDTH+BUS_W-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]                       wr_ptr, rd_ptr;
  logic [0:0]                        state;
  logic [NUM_COL-1:0]                pend, pend_next, mask;
  logic [NUM_COL-1:0][ID_WIDTH-1:0]  ids;
  logic [BUS_W-1:0]                  data;
  logic [ID_WIDTH-1:0]               head_tag;
  logic [BUS_W-1:0]                  head_data;
  logic                              full, empty, push, done, load;

  // extra pointer bit distinguishes full from empty
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = rstn & ~full;
  assign push      = in_valid & in_ready;
  assign head_tag  = mem[rd_ptr[AW-1:0]][ID_WIDTH+BUS_W-1:BUS_W];
  assign head_data = mem[rd_ptr[AW-1:0]][BUS_W-1:0];

  always_comb begin
    mask = '0;
    for (int c = 0; c < NUM_COL; c++)
      mask[c] = bcast | (&head_tag) | (head_tag == ids[c]);
  end

  // last handshake and next head load share one edge, so no bubble between entries
  assign pend_next = pend & ~col_ready;
  assign done      = (state == STATE_DELIVER) && (pend_next == '0);
  assign load      = ~empty && ((state == STATE_IDLE) || done);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {in_tag, in_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= STATE_IDLE;
      pend     <= '0;
      data     <= '0;
      drop_cnt <= '0;
      for (int c = 0; c < NUM_COL; c++) ids[c] <= ID_WIDTH'(c);
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (load) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        if (mask != '0) begin
          pend  <= mask;
          data  <= head_data;
          state <= STATE_DELIVER;
        end else begin
          pend  <= '0;
          state <= STATE_IDLE;
          if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
      end else if (state == STATE_DELIVER) begin
        pend <= pend_next;
        if (done) state <= STATE_IDLE;
      end
      // the load above already used the pre-write ID
      if (id_we) ids[cfg_col] <= cfg_id;
    end
  end

  assign col_valid = pend;
  assign col_data  = data;
  assign busy      = ~empty | (state == STATE_DELIVER);
endmodule

module multicast_router #(
  parameter int NUM_CH     = 3,
  parameter int NUM_COL    = 4,
  parameter int BUS_W      = 32,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8,
  localparam int CH_W      = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1,
  localparam int COL_W     = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*ID_WIDTH-1:0]   in_tag,
  input  logic [NUM_CH*BUS_W-1:0]      in_data,
  input  logic [NUM_CH-1:0]            ch_bcast,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [COL_W-1:0]             cfg_col,
  input  logic [ID_WIDTH-1:0]          cfg_id,
  output logic [NUM_CH*NUM_COL-1:0]    col_valid,
  output logic [NUM_CH*BUS_W-1:0]      col_data,
  input  logic [NUM_CH*NUM_COL-1:0]    col_ready,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH*CNT_W-1:0]      drop_cnt
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mcr_channel #(
      .NUM_COL(NUM_COL), .BUS_W(BUS_W), .ID_WIDTH(ID_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .COL_W(COL_W)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_tag    (in_tag[g*ID_WIDTH +: ID_WIDTH]),
      .in_data   (in_data[g*BUS_W +: BUS_W]),
      .bcast     (ch_bcast[g]),
      .id_we     (cfg_we && (cfg_ch == CH_W'(g))),
      .cfg_col   (cfg_col),
      .cfg_id    (cfg_id),
      .col_valid (col_valid[g*NUM_COL +: NUM_COL]),
      .col_data  (col_data[g*BUS_W +: BUS_W]),
      .col_ready (col_ready[g*NUM_COL +: NUM_COL]),
      .busy      (busy[g]),
      .drop_cnt  (drop_cnt[g*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_multicast_router.sv
// Directed-vector bench for multicast_router with hand-computed expectations.
module tb_multicast_router;
  localparam int NUM_CH = 3, NUM_COL = 4, BUS_W = 32, ID_WIDTH = 4, FIFO_DEPTH = 4, CNT_W = 8;

  logic                       clk = 1'b0;
  logic                       rstn = 1'b0;
  logic [NUM_CH-1:0]          in_valid, in_ready, ch_bcast, busy;
  logic [NUM_CH*ID_WIDTH-1:0] in_tag;
  logic [NUM_CH*BUS_W-1:0]    in_data, col_data;
  logic                       cfg_we;
  logic [1:0]                 cfg_ch, cfg_col;
  logic [ID_WIDTH-1:0]        cfg_id;
  logic [NUM_CH*NUM_COL-1:0]  col_valid, col_ready;
  logic [NUM_CH*CNT_W-1:0]    drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  multicast_router #(
    .NUM_CH(NUM_CH), .NUM_COL(NUM_COL), .BUS_W(BUS_W),
    .ID_WIDTH(ID_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_data(in_data), .ch_bcast(ch_bcast),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_col(cfg_col), .cfg_id(cfg_id),
    .col_valid(col_valid), .col_data(col_data), .col_ready(col_ready),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_COL-1:0] cv(input int ch);
    return col_valid[ch*NUM_COL +: NUM_COL];
  endfunction

  function automatic logic [BUS_W-1:0] cd(input int ch);
    return col_data[ch*BUS_W +: BUS_W];
  endfunction

  function automatic logic [CNT_W-1:0] dc(input int ch);
    return drop_cnt[ch*CNT_W +: CNT_W];
  endfunction

  task automatic push(input int ch, input logic [ID_WIDTH-1:0] tag, input logic [BUS_W-1:0] d);
    in_valid[ch] = 1'b1;
    in_tag[ch*ID_WIDTH +: ID_WIDTH] = tag;
    in_data[ch*BUS_W +: BUS_W] = d;
    step();
    in_valid[ch] = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] col, input logic [ID_WIDTH-1:0] id);
    cfg_we = 1'b1; cfg_ch = ch; cfg_col = col; cfg_id = id;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    in_valid = '0; in_tag = '0; in_data = '0; ch_bcast = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_col = '0; cfg_id = '0; col_ready = '0;

    // reset state
    #12;
    chk("rst_in_ready", in_ready, 3'b000);
    chk("rst_col_valid", col_valid, '0);
    chk("rst_busy", busy, 3'b000);
    chk("rst_drop_cnt", drop_cnt, '0);
    @(negedge clk) rstn = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 3'b111);

    // unicast ch0 tag 2
    push(0, 4'd2, 32'h1234);
    chk("uc_busy_q", busy[0], 1'b1);
    chk("uc_cv_early", cv(0), 4'b0000);
    step();
    chk("uc_cv", cv(0), 4'b0100);
    chk("uc_cd", cd(0), 32'h1234);
    col_ready[2] = 1'b1; step(); col_ready = '0;
    chk("uc_cv_done", cv(0), 4'b0000);
    chk("uc_busy_done", busy[0], 1'b0);

    // config write on the load edge uses the old ID
    push(2, 4'd1, 32'h11);
    cfg(2'd2, 2'd1, 4'd6);
    chk("cfgload_cv", cv(2), 4'b0010);
    col_ready[9] = 1'b1; step(); col_ready = '0;
    chk("cfgload_done", cv(2), 4'b0000);
    push(2, 4'd1, 32'h22);
    step();
    chk("cfgload_drop_cv", cv(2), 4'b0000);
    chk("cfgload_drop_cnt", dc(2), 8'd1);

    // staggered multicast on ch1
    cfg(2'd1, 2'd0, 4'd5); cfg(2'd1, 2'd1, 4'd5); cfg(2'd1, 2'd2, 4'd7); cfg(2'd1, 2'd3, 4'd5);
    push(1, 4'd5, 32'hA1);
    push(1, 4'd7, 32'hA2);
    chk("mc_pend", cv(1), 4'b1011);
    chk("mc_cd", cd(1), 32'hA1);
    col_ready[4] = 1'b1; step(); col_ready = '0;
    chk("mc_t0", cv(1), 4'b1010);
    step();
    chk("mc_t1", cv(1), 4'b1010);
    col_ready[7] = 1'b1; step(); col_ready = '0;
    chk("mc_t2", cv(1), 4'b0010);
    step(); step();
    chk("mc_t4", cv(1), 4'b0010);
    chk("mc_t4_busy", busy[1], 1'b1);
    col_ready[5] = 1'b1; step(); col_ready = '0;
    chk("mc_t5_next", cv(1), 4'b0100);
    chk("mc_t5_cd", cd(1), 32'hA2);
    col_ready[6] = 1'b1; step(); col_ready = '0;
    chk("mc_end_cv", cv(1), 4'b0000);
    chk("mc_end_busy", busy[1], 1'b0);

    // broadcast tag and broadcast mode
    push(2, 4'hF, 32'hB0);
    step();
    chk("bc_tag", cv(2), 4'b1111);
    col_ready[11:8] = 4'hF; step(); col_ready = '0;
    chk("bc_tag_done", cv(2), 4'b0000);
    ch_bcast[0] = 1'b1;
    push(0, 4'd9, 32'hC0);
    step();
    ch_bcast[0] = 1'b0;
    chk("bc_mode", cv(0), 4'b1111);
    chk("bc_mode_cd", cd(0), 32'hC0);
    col_ready[3:0] = 4'hF; step(); col_ready = '0;
    chk("bc_mode_done", cv(0), 4'b0000);
    chk("bc_no_drop", dc(0), 8'd0);

    // drop and saturation
    push(0, 4'd9, 32'hDD);
    step();
    chk("drop_cv", cv(0), 4'b0000);
    chk("drop_cnt1", dc(0), 8'd1);
    chk("drop_busy", busy[0], 1'b0);
    in_valid[0] = 1'b1; in_tag[3:0] = 4'd9;
    repeat (300) step();
    in_valid[0] = 1'b0;
    step(); step();
    chk("drop_sat", dc(0), 8'd255);
    chk("drop_other_ch", dc(1), 8'd0);

    // backpressure: 1 latched + 4 queued
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready[0], 1'b1);
      in_valid[0] = 1'b1; in_tag[3:0] = 4'd1; in_data[31:0] = 32'hD000 + 32'(i);
      step();
    end
    in_valid[0] = 1'b0;
    chk("bp_full", in_ready[0], 1'b0);
    chk("bp_cv", cv(0), 4'b0010);
    chk("bp_cd0", cd(0), 32'hD000);
    col_ready[1] = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("bp_cd_seq", cd(0), 32'hD000 + 32'(i));
      chk("bp_cv_seq", cv(0), 4'b0010);
    end
    step();
    col_ready = '0;
    chk("bp_end_cv", cv(0), 4'b0000);
    chk("bp_end_busy", busy[0], 1'b0);

    // reset mid-delivery
    cfg(2'd0, 2'd0, 4'd3);
    for (int i = 0; i < 4; i++) push(0, 4'd3, 32'hE000 + 32'(i));
    chk("mr_cv", cv(0), 4'b1001);
    chk("mr_cd", cd(0), 32'hE000);
    #2 rstn = 1'b0;
    #1;
    chk("mr_cv_rst", col_valid, '0);
    chk("mr_rdy_rst", in_ready, 3'b000);
    chk("mr_drop_rst", drop_cnt, '0);
    @(negedge clk) rstn = 1'b1;
    step();
    chk("mr_busy", busy, 3'b000);
    chk("mr_in_ready", in_ready, 3'b111);
    push(0, 4'd3, 32'hF0);
    step();
    chk("mr_id_revert", cv(0), 4'b1000);
    col_ready[3] = 1'b1; step(); col_ready = '0;
    chk("mr_final", cv(0), 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
